// File: rtl/spi_ram_burst.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram_burst
//  Brief    : Command-decoded single-port RAM behind an SPI slave receive path.
//             2-bit commands set write/read pointers or move data. Optional
//             post-increment gives bursts, and a sequence-error pulse flags
//             rejected commands.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              seq_err
);

    localparam logic [1:0]        c_CMD_WR_ADDR = 2'b00;
    localparam logic [1:0]        c_CMD_WR_DATA = 2'b01;
    localparam logic [1:0]        c_CMD_RD_ADDR = 2'b10;
    localparam logic [1:0]        c_CMD_RD_DATA = 2'b11;
    // One extra bit so MEM_DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   c_DEPTH       = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST        = ADDR_W'(MEM_DEPTH - 1);

    logic [DATA_W-1:0] r_mem [0:MEM_DEPTH-1];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_wr_armed;
    logic              r_rd_armed;
    logic [DATA_W-1:0] r_dout;
    logic              r_tx_valid;
    logic              r_seq_err;

    logic [1:0]        w_cmd;
    logic [DATA_W-1:0] w_payload;
    logic [ADDR_W-1:0] w_addr;
    logic              w_addr_ok;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_next;
    logic [ADDR_W-1:0] w_rd_next;

    assign w_cmd     = din[DATA_W+1:DATA_W];
    assign w_payload = din[DATA_W-1:0];
    assign w_addr    = din[ADDR_W-1:0];
    assign w_addr_ok = ({1'b0, w_addr} < c_DEPTH);
    assign w_wr_en   = rx_valid && (w_cmd == c_CMD_WR_DATA) && r_wr_armed;

    // Pointer advance wraps at the last valid word, not at 2**ADDR_W, so a
    // pointer can never leave the populated range.
    generate
        if (AUTO_INC != 0) begin : g_auto_inc
            assign w_wr_next = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + ADDR_W'(1);
            assign w_rd_next = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + ADDR_W'(1);
        end else begin : g_static_ptr
            assign w_wr_next = r_wr_ptr;
            assign w_rd_next = r_rd_ptr;
        end
    endgenerate

    // Storage array: written at the sampling edge, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_payload;
        end
    end

    // Command decode: pointers, arming flags and registered response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
            r_dout     <= '0;
            r_tx_valid <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_seq_err  <= 1'b0;
            if (rx_valid) begin
                case (w_cmd)
                    c_CMD_WR_ADDR: begin
                        if (w_addr_ok) begin
                            r_wr_ptr   <= w_addr;
                            r_wr_armed <= 1'b1;
                        end else begin
                            r_seq_err  <= 1'b1;
                        end
                    end
                    c_CMD_WR_DATA: begin
                        if (r_wr_armed) begin
                            r_wr_ptr  <= w_wr_next;
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                    c_CMD_RD_ADDR: begin
                        if (w_addr_ok) begin
                            r_rd_ptr   <= w_addr;
                            r_rd_armed <= 1'b1;
                        end else begin
                            r_seq_err  <= 1'b1;
                        end
                    end
                    default: begin
                        if (r_rd_armed) begin
                            r_dout     <= r_mem[r_rd_ptr];
                            r_tx_valid <= 1'b1;
                            r_rd_ptr   <= w_rd_next;
                        end else begin
                            r_seq_err  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign seq_err  = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_ram_burst
//  Brief    : Directed self-checking bench for spi_ram_burst. Three instances
//             cover the default build, a 200-word depth and static pointers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_burst;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic [2:0] rxv;

    logic [7:0] dout0, dout1, dout2;
    logic       tx0, tx1, tx2;
    logic       se0, se1, se2;

    int checks;
    int errors;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxv[0]), .din(din),
        .dout(dout0), .tx_valid(tx0), .seq_err(se0)
    );

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut_d200 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxv[1]), .din(din),
        .dout(dout1), .tx_valid(tx1), .seq_err(se1)
    );

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut_static (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxv[2]), .din(din),
        .dout(dout2), .tx_valid(tx2), .seq_err(se2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one command to one instance for exactly one sampling edge;
    // outputs are then observed 1 time unit after that edge.
    task automatic cmd(input int which, input logic [1:0] c, input logic [7:0] pl);
        din        = {c, pl};
        rxv        = 3'b000;
        rxv[which] = 1'b1;
        @(posedge clk);
        #1;
        rxv = 3'b000;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxv   = 3'b000;
        din   = '0;
        repeat (3) idle_cycle();
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout0); end
        checks++; if ({tx0, tx1, tx2} !== 3'b000) begin errors++; $display("FAIL reset_tx: got %b expected 000", {tx0, tx1, tx2}); end
        checks++; if ({se0, se1, se2} !== 3'b000) begin errors++; $display("FAIL reset_seq_err: got %b expected 000", {se0, se1, se2}); end
        rst_n = 1'b1;
        idle_cycle();
        cmd(0, 2'b00, 8'h03);
        cmd(0, 2'b01, 8'h5A);
        cmd(0, 2'b10, 8'h03);
        cmd(0, 2'b11, 8'h00);
        checks++; if (tx0 !== 1'b1 || dout0 !== 8'h5A) begin errors++; $display("FAIL reset_setup_read: got tx=%b dout=%h expected tx=1 dout=5a", tx0, dout0); end
        // Asynchronous reset in the middle of the cycle holding tx_valid.
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tx0 !== 1'b0 || dout0 !== 8'h00) begin errors++; $display("FAIL reset_async: got tx=%b dout=%h expected tx=0 dout=00", tx0, dout0); end
        idle_cycle();
        rst_n = 1'b1;
        cmd(0, 2'b11, 8'h00);
        checks++; if (se0 !== 1'b1 || tx0 !== 1'b0) begin errors++; $display("FAIL reset_unarmed_read: got se=%b tx=%b expected se=1 tx=0", se0, tx0); end
        idle_cycle();
        checks++; if (se0 !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got se=%b expected 0", se0); end
    endtask

    task automatic test_write_read_single();
        cmd(0, 2'b00, 8'h05);
        checks++; if (se0 !== 1'b0 || tx0 !== 1'b0) begin errors++; $display("FAIL single_addr_resp: got se=%b tx=%b expected 0 0", se0, tx0); end
        cmd(0, 2'b01, 8'hA5);
        cmd(0, 2'b10, 8'h05);
        cmd(0, 2'b11, 8'h00);
        checks++; if (tx0 !== 1'b1 || dout0 !== 8'hA5) begin errors++; $display("FAIL single_read: got tx=%b dout=%h expected tx=1 dout=a5", tx0, dout0); end
        idle_cycle();
        checks++; if (tx0 !== 1'b0 || dout0 !== 8'hA5) begin errors++; $display("FAIL single_hold: got tx=%b dout=%h expected tx=0 dout=a5", tx0, dout0); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] exp_data [3];
        exp_data[0] = 8'h11;
        exp_data[1] = 8'h22;
        exp_data[2] = 8'h33;
        cmd(0, 2'b00, 8'hFE);
        for (int i = 0; i < 3; i++) cmd(0, 2'b01, exp_data[i]);
        cmd(0, 2'b10, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            cmd(0, 2'b11, 8'h00);
            checks++; if (tx0 !== 1'b1 || dout0 !== exp_data[i]) begin errors++; $display("FAIL burst_read[%0d]: got tx=%b dout=%h expected tx=1 dout=%h", i, tx0, dout0, exp_data[i]); end
        end
        idle_cycle();
        checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL burst_end_tx: got %b expected 0", tx0); end
        cmd(0, 2'b10, 8'h00);
        cmd(0, 2'b11, 8'h00);
        checks++; if (dout0 !== 8'h33) begin errors++; $display("FAIL burst_wrap_addr0: got %h expected 33", dout0); end
    endtask

    task automatic test_out_of_range();
        cmd(1, 2'b00, 8'hC8);
        checks++; if (se1 !== 1'b1 || tx1 !== 1'b0) begin errors++; $display("FAIL oor_wr_addr: got se=%b tx=%b expected se=1 tx=0", se1, tx1); end
        cmd(1, 2'b01, 8'h77);
        checks++; if (se1 !== 1'b1) begin errors++; $display("FAIL oor_wr_data: got se=%b expected 1", se1); end
        cmd(1, 2'b10, 8'hC8);
        checks++; if (se1 !== 1'b1) begin errors++; $display("FAIL oor_rd_addr: got se=%b expected 1", se1); end
        cmd(1, 2'b11, 8'h00);
        checks++; if (se1 !== 1'b1 || tx1 !== 1'b0 || dout1 !== 8'h00) begin errors++; $display("FAIL oor_rd_data: got se=%b tx=%b dout=%h expected 1 0 00", se1, tx1, dout1); end
        idle_cycle();
        checks++; if (se1 !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got se=%b expected 0", se1); end
        // Last in-range word, then wrap from 199 to 0.
        cmd(1, 2'b00, 8'hC7);
        checks++; if (se1 !== 1'b0) begin errors++; $display("FAIL d200_last_addr: got se=%b expected 0", se1); end
        cmd(1, 2'b01, 8'h99);
        cmd(1, 2'b01, 8'hAA);
        cmd(1, 2'b01, 8'hBB);
        cmd(1, 2'b10, 8'h00);
        cmd(1, 2'b11, 8'h00);
        checks++; if (tx1 !== 1'b1 || dout1 !== 8'hAA) begin errors++; $display("FAIL d200_wrap0: got tx=%b dout=%h expected tx=1 dout=aa", tx1, dout1); end
        cmd(1, 2'b11, 8'h00);
        checks++; if (dout1 !== 8'hBB) begin errors++; $display("FAIL d200_wrap1: got %h expected bb", dout1); end
        cmd(1, 2'b10, 8'hC7);
        cmd(1, 2'b11, 8'h00);
        checks++; if (dout1 !== 8'h99) begin errors++; $display("FAIL d200_last: got %h expected 99", dout1); end
        cmd(1, 2'b11, 8'h00);
        checks++; if (dout1 !== 8'hAA) begin errors++; $display("FAIL d200_rd_wrap: got %h expected aa", dout1); end
    endtask

    task automatic test_static_ptr();
        cmd(2, 2'b00, 8'h10);
        cmd(2, 2'b01, 8'h01);
        cmd(2, 2'b01, 8'h02);
        cmd(2, 2'b10, 8'h10);
        cmd(2, 2'b11, 8'h00);
        checks++; if (tx2 !== 1'b1 || dout2 !== 8'h02) begin errors++; $display("FAIL static_read0: got tx=%b dout=%h expected tx=1 dout=02", tx2, dout2); end
        cmd(2, 2'b11, 8'h00);
        checks++; if (tx2 !== 1'b1 || dout2 !== 8'h02) begin errors++; $display("FAIL static_read1: got tx=%b dout=%h expected tx=1 dout=02", tx2, dout2); end
    endtask

    task automatic test_idle_gaps();
        logic [1:0] c_seq [4];
        logic [7:0] p_seq [4];
        c_seq[0] = 2'b00; p_seq[0] = 8'h06;
        c_seq[1] = 2'b01; p_seq[1] = 8'h3C;
        c_seq[2] = 2'b10; p_seq[2] = 8'h06;
        c_seq[3] = 2'b11; p_seq[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            cmd(0, c_seq[i], p_seq[i]);
            if (i == 3) begin
                checks++; if (tx0 !== 1'b1 || dout0 !== 8'h3C) begin errors++; $display("FAIL gap_read: got tx=%b dout=%h expected tx=1 dout=3c", tx0, dout0); end
            end
            for (int g = 0; g < 2; g++) begin
                idle_cycle();
                checks++; if (tx0 !== 1'b0 || se0 !== 1'b0) begin errors++; $display("FAIL gap_quiet[%0d.%0d]: got tx=%b se=%b expected 0 0", i, g, tx0, se0); end
            end
        end
        checks++; if (dout0 !== 8'h3C) begin errors++; $display("FAIL gap_hold: got %h expected 3c", dout0); end
    endtask

    task automatic test_back_to_back();
        cmd(0, 2'b00, 8'h40);
        cmd(0, 2'b10, 8'h40);
        cmd(0, 2'b01, 8'h5F);
        cmd(0, 2'b11, 8'h00);
        checks++; if (tx0 !== 1'b1 || dout0 !== 8'h5F) begin errors++; $display("FAIL b2b_read0: got tx=%b dout=%h expected tx=1 dout=5f", tx0, dout0); end
        cmd(0, 2'b01, 8'h60);
        checks++; if (tx0 !== 1'b0 || se0 !== 1'b0) begin errors++; $display("FAIL b2b_write_resp: got tx=%b se=%b expected 0 0", tx0, se0); end
        cmd(0, 2'b11, 8'h00);
        checks++; if (tx0 !== 1'b1 || dout0 !== 8'h60) begin errors++; $display("FAIL b2b_read1: got tx=%b dout=%h expected tx=1 dout=60", tx0, dout0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rxv    = 3'b000;
        din    = '0;
        test_reset();
        test_write_read_single();
        test_burst_wrap();
        test_out_of_range();
        test_static_ptr();
        test_idle_gaps();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
